id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS pipeline.
- Sits directly downstream of the register file. Captures the two operand read values, instruction register fields, the sign-extended immediate and decoded control into the EX stage.
- Detects load-use hazards, inserts bubbles, and honours branch flush and external hold.
- Keeps a saturating bubble counter for performance debug.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/load_use_detect.sv | 22 ++
 rtl/id_ex_stage.sv | 169 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: widths, ALU op codes
// and the decoded control bundle carried between stages.
package mips_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 3;

    // ALU operation encodings driven by the decoder.
    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 3'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 3'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 3'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 3'd7;

    // Decoded control for one instruction. A bubble is all zeros, so it can
    // never write the register file or touch memory downstream.
    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic               reg_dst;
        logic               branch;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load currently in EX will write. Pure combinational, shared with IF/ID.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    output logic              luh_o
);

    // $zero is never a real dependency, so a load targeting r0 is ignored.
    always_comb begin
        luh_o = ex_valid_i & ex_mem_read_i & id_valid_i &
                (ex_rt_i != '0) &
                ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Captures operands, register fields, immediate and
// decoded control one cycle after ID. Inserts a bubble on branch flush or a
// load-use hazard, freezes on external stall, and counts inserted bubbles
// in a saturating counter for performance debug.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic [DATA_W-1:0]  id_rdata_rs,
    input  logic [DATA_W-1:0]  id_rdata_rt,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    input  logic               id_alu_src,
    input  logic               id_reg_dst,
    input  logic               id_branch,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               flush_i,
    input  logic               stall_i,
    output logic               ex_valid,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_rd,
    output logic [DATA_W-1:0]  ex_rdata_rs,
    output logic [DATA_W-1:0]  ex_rdata_rt,
    output logic [DATA_W-1:0]  ex_imm,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_alu_src,
    output logic               ex_reg_dst,
    output logic               ex_branch,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               hazard_stall_o,
    output logic [CNT_W-1:0]   bubble_count
);

    import mips_pkg::*;

    logic              valid_q, valid_d;
    logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] rdata_rs_q, rdata_rs_d;
    logic [DATA_W-1:0] rdata_rt_q, rdata_rt_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    ctrl_t             ctrl_q, ctrl_d;
    ctrl_t             id_ctrl;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              luh;
    logic              bubble;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_luh (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rt_i       (rt_q),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .luh_o         (luh)
    );

    // Pack the decoder outputs into one bundle for uniform handling.
    always_comb begin
        id_ctrl            = CTRL_BUBBLE;
        id_ctrl.reg_write  = id_reg_write;
        id_ctrl.mem_read   = id_mem_read;
        id_ctrl.mem_write  = id_mem_write;
        id_ctrl.mem_to_reg = id_mem_to_reg;
        id_ctrl.alu_src    = id_alu_src;
        id_ctrl.reg_dst    = id_reg_dst;
        id_ctrl.branch     = id_branch;
        id_ctrl.alu_op     = id_alu_op;
    end

    // Flush beats stall beats hazard; only a real hazard asks upstream to hold.
    always_comb begin
        bubble         = flush_i | (~stall_i & luh);
        hazard_stall_o = luh & ~flush_i & ~stall_i;
    end

    // Next-state: bubble, hold, or capture the ID instruction.
    always_comb begin
        valid_d    = valid_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        rdata_rs_d = rdata_rs_q;
        rdata_rt_d = rdata_rt_q;
        imm_d      = imm_q;
        ctrl_d     = ctrl_q;
        cnt_d      = cnt_q;
        if (bubble) begin
            valid_d    = 1'b0;
            rs_d       = '0;
            rt_d       = '0;
            rd_d       = '0;
            rdata_rs_d = '0;
            rdata_rt_d = '0;
            imm_d      = '0;
            ctrl_d     = CTRL_BUBBLE;
            cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (!stall_i) begin
            valid_d    = id_valid;
            rs_d       = id_rs;
            rt_d       = id_rt;
            rd_d       = id_rd;
            // r0 reads as zero even if the register file holds garbage there.
            rdata_rs_d = (id_rs == '0) ? '0 : id_rdata_rs;
            rdata_rt_d = (id_rt == '0) ? '0 : id_rdata_rt;
            imm_d      = id_imm;
            ctrl_d     = id_valid ? id_ctrl : CTRL_BUBBLE;
        end
    end

    // Pipeline register and bubble counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rdata_rs_q <= '0;
            rdata_rt_q <= '0;
            imm_q      <= '0;
            ctrl_q     <= CTRL_BUBBLE;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            rdata_rs_q <= rdata_rs_d;
            rdata_rt_q <= rdata_rt_d;
            imm_q      <= imm_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_rd         = rd_q;
    assign ex_rdata_rs   = rdata_rs_q;
    assign ex_rdata_rt   = rdata_rt_q;
    assign ex_imm        = imm_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_dst    = ctrl_q.reg_dst;
    assign ex_branch     = ctrl_q.branch;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign bubble_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed steps, a reference model of
// the ID/EX register, and an expected queue compared after each posedge.
module tb_id_ex_stage;

    localparam int OUT_W = 1 + 3*5 + 3*32 + 10 + 16;

    // Control vector order: rw, mr, mw, m2r, as, rd, br, alu_op[2:0]
    localparam logic [9:0] C_NONE = 10'b0000000_000;
    localparam logic [9:0] C_RTYP = 10'b1000010_000;
    localparam logic [9:0] C_ADDI = 10'b1000100_000;
    localparam logic [9:0] C_LW   = 10'b1101100_000;
    localparam logic [9:0] C_SW   = 10'b0010100_000;
    localparam logic [9:0] C_BEQ  = 10'b0000001_001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic [31:0] id_rdata_rs = '0, id_rdata_rt = '0, id_imm = '0;
    logic [9:0]  id_ctrl = '0;
    logic        flush_i = 1'b0, stall_i = 1'b0;

    logic        ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rdata_rs, ex_rdata_rt, ex_imm;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        ex_alu_src, ex_reg_dst, ex_branch;
    logic [2:0]  ex_alu_op;
    logic        hazard_stall_o;
    logic [15:0] bubble_count;

    // Reference model state
    logic        m_valid;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_a, m_b, m_imm;
    logic [9:0]  m_ctrl;
    logic [15:0] m_cnt;

    logic [OUT_W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    id_ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_rdata_rs    (id_rdata_rs),
        .id_rdata_rt    (id_rdata_rt),
        .id_imm         (id_imm),
        .id_reg_write   (id_ctrl[9]),
        .id_mem_read    (id_ctrl[8]),
        .id_mem_write   (id_ctrl[7]),
        .id_mem_to_reg  (id_ctrl[6]),
        .id_alu_src     (id_ctrl[5]),
        .id_reg_dst     (id_ctrl[4]),
        .id_branch      (id_ctrl[3]),
        .id_alu_op      (id_ctrl[2:0]),
        .flush_i        (flush_i),
        .stall_i        (stall_i),
        .ex_valid       (ex_valid),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .ex_rd          (ex_rd),
        .ex_rdata_rs    (ex_rdata_rs),
        .ex_rdata_rt    (ex_rdata_rt),
        .ex_imm         (ex_imm),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_mem_to_reg  (ex_mem_to_reg),
        .ex_alu_src     (ex_alu_src),
        .ex_reg_dst     (ex_reg_dst),
        .ex_branch      (ex_branch),
        .ex_alu_op      (ex_alu_op),
        .hazard_stall_o (hazard_stall_o),
        .bubble_count   (bubble_count)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] dut_vec();
        return {ex_valid, ex_rs, ex_rt, ex_rd, ex_rdata_rs, ex_rdata_rt, ex_imm,
                ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                ex_alu_src, ex_reg_dst, ex_branch, ex_alu_op, bubble_count};
    endfunction

    function automatic logic [OUT_W-1:0] model_vec();
        return {m_valid, m_rs, m_rt, m_rd, m_a, m_b, m_imm, m_ctrl, m_cnt};
    endfunction

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs,
                       input logic [OUT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm,
                          input logic [9:0] c);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_rdata_rs = a;
        id_rdata_rt = b;
        id_imm      = imm;
        id_ctrl     = c;
    endtask

    task automatic model_bubble();
        m_valid = 1'b0;
        m_rs = '0; m_rt = '0; m_rd = '0;
        m_a = '0; m_b = '0; m_imm = '0;
        m_ctrl = '0;
        m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
    endtask

    // One clock: check the hazard output, predict EX contents, compare after the edge.
    task automatic step();
        logic luh, exp_hz;
        #1;
        luh = m_valid & m_ctrl[8] & id_valid & (m_rt != 5'd0) &
              ((m_rt == id_rs) | (m_rt == id_rt));
        exp_hz = luh & ~flush_i & ~stall_i;
        if (!rst) chk("hazard_stall", OUT_W'(hazard_stall_o), OUT_W'(exp_hz));
        if (rst) begin
            m_valid = 1'b0;
            m_rs = '0; m_rt = '0; m_rd = '0;
            m_a = '0; m_b = '0; m_imm = '0;
            m_ctrl = '0; m_cnt = '0;
        end else if (flush_i) begin
            model_bubble();
        end else if (stall_i) begin
            // hold
        end else if (luh) begin
            model_bubble();
        end else begin
            m_valid = id_valid;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_a = (id_rs == 5'd0) ? 32'd0 : id_rdata_rs;
            m_b = (id_rt == 5'd0) ? 32'd0 : id_rdata_rt;
            m_imm = id_imm;
            m_ctrl = id_valid ? id_ctrl : 10'd0;
        end
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            chk("ex_regs", dut_vec(), exp_q.pop_front());
        end
    endtask

    initial begin
        m_valid = 0; m_rs = 0; m_rt = 0; m_rd = 0;
        m_a = 0; m_b = 0; m_imm = 0; m_ctrl = 0; m_cnt = 0;

        // Reset with live-looking ID inputs
        rst = 1'b1;
        set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
               $urandom, 10'($urandom));
        step();
        set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
               $urandom, C_LW);
        step();
        chk("reset_valid", OUT_W'(ex_valid), OUT_W'(0));
        chk("reset_count", OUT_W'(bubble_count), OUT_W'(0));
        rst = 1'b0;
        #1;
        chk("reset_hazard", OUT_W'(hazard_stall_o), OUT_W'(0));

        // Normal capture
        set_id(1'b1, 5'd3, 5'd4, 5'd7, 32'h11, 32'h22, 32'hFFFF_FFF0, C_RTYP);
        step();
        chk("cap_rdata_rs", OUT_W'(ex_rdata_rs), OUT_W'(32'h11));
        chk("cap_imm", OUT_W'(ex_imm), OUT_W'(32'hFFFF_FFF0));
        chk("cap_valid_rw", OUT_W'({ex_valid, ex_reg_write}), OUT_W'(2'b11));

        // Load-use: lw r5, then a consumer of r5
        set_id(1'b1, 5'd2, 5'd5, 5'd0, 32'h100, 32'h0, 32'h8, C_LW);
        step();
        set_id(1'b1, 5'd5, 5'd6, 5'd8, 32'h55, 32'h66, 32'h0, C_RTYP);
        #1;
        chk("luh_hazard_hi", OUT_W'(hazard_stall_o), OUT_W'(1));
        step();
        chk("luh_bubble", OUT_W'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}),
            OUT_W'(0));
        chk("luh_count", OUT_W'(bubble_count), OUT_W'(1));
        #1;
        chk("luh_hazard_lo", OUT_W'(hazard_stall_o), OUT_W'(0));
        step();
        chk("luh_captured", OUT_W'({ex_valid, ex_rs}), OUT_W'({1'b1, 5'd5}));

        // No false hazard on r0 and the r0 read guard
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'h7, 32'h0, 32'h4, C_LW);
        step();
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 32'hDEAD, 32'hBEEF, 32'h0, C_RTYP);
        #1;
        chk("r0_no_hazard", OUT_W'(hazard_stall_o), OUT_W'(0));
        step();
        chk("r0_rdata", OUT_W'({ex_rdata_rs, ex_rdata_rt}), OUT_W'(0));

        // Flush together with a load-use condition
        set_id(1'b1, 5'd3, 5'd9, 5'd0, 32'h30, 32'h0, 32'hC, C_LW);
        step();
        set_id(1'b1, 5'd9, 5'd1, 5'd2, 32'h99, 32'h11, 32'h0, C_RTYP);
        flush_i = 1'b1;
        #1;
        chk("flush_hazard", OUT_W'(hazard_stall_o), OUT_W'(0));
        step();
        flush_i = 1'b0;
        chk("flush_count", OUT_W'(bubble_count), OUT_W'(2));

        // Stall together with a load-use condition: hold, then hazard returns
        set_id(1'b1, 5'd3, 5'd9, 5'd0, 32'h30, 32'h0, 32'hC, C_LW);
        step();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'd9, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   $urandom, $urandom, $urandom, C_ADDI);
            step();
        end
        chk("stall_frozen", OUT_W'({ex_valid, ex_rt, ex_mem_read}),
            OUT_W'({1'b1, 5'd9, 1'b1}));
        chk("stall_count", OUT_W'(bubble_count), OUT_W'(2));
        stall_i = 1'b0;
        #1;
        chk("stall_release_hazard", OUT_W'(hazard_stall_o), OUT_W'(1));
        step();
        chk("stall_release_count", OUT_W'(bubble_count), OUT_W'(3));

        // Reset in the middle of a stalled load-use
        set_id(1'b1, 5'd4, 5'd12, 5'd0, 32'h40, 32'h0, 32'h10, C_LW);
        step();
        set_id(1'b1, 5'd12, 5'd0, 5'd3, 32'h1, 32'h2, 32'h3, C_SW);
        stall_i = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        stall_i = 1'b0;
        #1;
        chk("rst_mid_stall_hazard", OUT_W'(hazard_stall_o), OUT_W'(0));
        chk("rst_mid_stall_valid", OUT_W'({ex_valid, bubble_count}), OUT_W'(0));

        // Random mix of dependent instructions, flushes and stalls
        for (int i = 0; i < 40; i++) begin
            logic [9:0] c;
            case ($urandom_range(0, 4))
                0: c = C_LW;
                1: c = C_SW;
                2: c = C_BEQ;
                3: c = C_ADDI;
                default: c = C_RTYP;
            endcase
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                   $urandom, $urandom, $urandom, c);
            flush_i = ($urandom_range(0, 7) == 0);
            stall_i = ($urandom_range(0, 5) == 0);
            step();
        end
        flush_i = 1'b0;
        stall_i = 1'b0;

        // Saturation: a long run of flushes pins the counter at all-ones
        flush_i = 1'b1;
        repeat (65535) begin
            @(posedge clk);
            model_bubble();
        end
        #1;
        chk("sat_reach", OUT_W'(bubble_count), OUT_W'(16'hFFFF));
        step();
        chk("sat_hold", OUT_W'(bubble_count), OUT_W'(16'hFFFF));
        flush_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
